// File: rtl/serial_bus_master_port.sv
// serial_bus_master_port: serial bus master sending a control frame, then shifting write words out or read words in.
// Define BUS_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES consecutive stalled bus cycles.
module serial_bus_master_port #(
  parameter int DATA_WIDTH     = 8,
  parameter int SLAVES         = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_slave,
  input  logic                  cmd_write,
  input  logic [3:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  input  logic                  rD,
  input  logic                  ready
);
  localparam int FW = ID_WIDTH + 2;
  localparam int CW = $clog2(FW);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, CTRL, WRITE, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [4:0] word_q, word_d;
  logic [3:0] len_q, len_d;
  logic write_q, write_d, full_q, full_d, rd_valid_q, rd_valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, rd_data_q, rd_data_d;
  logic to, last_bit, fire, samp;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic stall;
  assign stall = (state_q == WRITE && full_q) || state_q == READ;
  assign to = stall && tcnt_q == TW'(TIMEOUT_CYCLES);
  assign tcnt_d = (stall && !ready && !to) ? tcnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
`else
  assign to = 1'b0;
`endif
  assign last_bit = bit_q == BW'(DATA_WIDTH - 1);
  assign fire = state_q == WRITE && full_q && ready;
  assign samp = state_q == READ && ready;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    ccnt_d = ccnt_q;
    bit_d = bit_q;
    word_d = word_q;
    len_d = len_q;
    write_d = write_q;
    full_d = full_q;
    sh_d = sh_q;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    err_d = 1'b0;
    cmd_ready = state_q == IDLE;
    // a word may load while the previous word's last bit leaves, but never beyond the burst length
    wr_ready = (state_q == CTRL || state_q == WRITE) && write_q && (!full_q || (fire && last_bit))
               && word_q + 5'(full_q) <= {1'b0, len_q};
    control = state_q == CTRL && frame_q[FW-1];
    valid = ((state_q == WRITE && full_q) || state_q == READ) && !to;
    wD = state_q == WRITE && full_q && !to && sh_q[DATA_WIDTH-1];
    done = state_q == DONE || to;
    err = err_q || to;
    case (state_q)
      IDLE: if (cmd_valid) begin
        len_d = cmd_len;
        write_d = cmd_write;
        if (32'(cmd_slave) >= SLAVES) err_d = 1'b1;
        else begin
          state_d = CTRL;
          frame_d = {1'b1, cmd_slave, cmd_write};
        end
      end
      CTRL: begin
        frame_d = frame_q << 1;
        ccnt_d = ccnt_q + 1'b1;
        if (ccnt_q == CW'(FW - 1)) state_d = write_q ? WRITE : READ;
      end
      WRITE: if (fire) begin
        sh_d = sh_q << 1;
        bit_d = last_bit ? '0 : bit_q + 1'b1;
        if (last_bit) begin
          full_d = 1'b0;
          word_d = word_q + 1'b1;
          if (word_q == {1'b0, len_q}) state_d = DONE;
        end
      end
      READ: if (samp) begin
        sh_d = {sh_q[DATA_WIDTH-2:0], rD};
        bit_d = last_bit ? '0 : bit_q + 1'b1;
        if (last_bit) begin
          rd_data_d = sh_d;
          rd_valid_d = 1'b1;
          word_d = word_q + 1'b1;
          if (word_q == {1'b0, len_q}) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ready && wr_valid) begin
      full_d = 1'b1;
      sh_d = wr_data;
    end
    if (to) state_d = IDLE;
    if (state_d == IDLE) begin
      ccnt_d = '0;
      bit_d = '0;
      word_d = '0;
      full_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      ccnt_q <= '0;
      bit_q <= '0;
      word_q <= '0;
      len_q <= '0;
      write_q <= 1'b0;
      full_q <= 1'b0;
      sh_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      ccnt_q <= ccnt_d;
      bit_q <= bit_d;
      word_q <= word_d;
      len_q <= len_d;
      write_q <= write_d;
      full_q <= full_d;
      sh_q <= sh_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_serial_bus_master_port.sv
// tb_serial_bus_master_port: directed table, corner sequences and random bursts against a bit-stream level model.
module tb_serial_bus_master_port;
  localparam int DW = 8, IW = 2, NS = 3, TO = 16, FW = IW + 2;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_write = 0, wr_valid = 0, rD = 0, ready = 0;
  logic [IW-1:0] cmd_slave = '0;
  logic [3:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic cmd_ready, wr_ready, rd_valid, done, err, control, wD, valid;
  logic [DW-1:0] rd_data;
  int checks = 0, failures = 0;
  typedef struct {int sl; bit wr; int len; logic [7:0] w0; logic [7:0] w1; int sbit; int sn; int exp_done;} vec_t;
  vec_t vecs[6];

  serial_bus_master_port #(.DATA_WIDTH(DW), .SLAVES(NS), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave),
    .cmd_write(cmd_write), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .control(control), .wD(wD),
    .valid(valid), .rD(rD), .ready(ready));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One command; the model is the expected frame, the expected bit stream and the word counts.
  task automatic txn(input int sl, input bit wr, input int len, input logic [7:0] w0, input logic [7:0] w1,
                     input int sbit, input int sn, input int spct, input int vpct, input int exp_done);
    logic [7:0] wq [16];
    logic [7:0] rq [16];
    logic [FW-1:0] ctl;
    logic pv, pr, pw, stalled;
    int cyc, bits, wi, rc, sc, dcnt, ecnt, dcyc, ecyc, lastx, ctl_bad, bit_bad, hold_bad, total;
    bit bad_sl, stop;
    bad_sl = sl >= NS;
    for (int i = 0; i < 16; i++) begin
      wq[i] = 8'($urandom);
      rq[i] = 8'($urandom);
    end
    wq[0] = w0; wq[1] = w1; rq[0] = w0; rq[1] = w1;
    total = bad_sl ? 0 : (len + 1) * DW;
    ctl = '0; pv = 0; pr = 0; pw = 0; stop = 0;
    cyc = 0; bits = 0; wi = 0; rc = 0; sc = 0; dcnt = 0; ecnt = 0; dcyc = -1; ecyc = -1; lastx = -1;
    ctl_bad = 0; bit_bad = 0; hold_bad = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_slave = IW'(sl); cmd_write = wr; cmd_len = 4'(len); ready = 1; wr_valid = 0;
    #1 chk("accept_ready", cmd_ready, 1);
    while (!stop) begin
      @(negedge clk);
      cyc++;
      cmd_valid = !bad_sl && dcnt == 0 && $urandom_range(1) == 1;
      cmd_slave = IW'($urandom); cmd_write = 1'($urandom); cmd_len = 4'($urandom);
      stalled = bits == sbit && sc < sn;
      if (stalled) sc++;
      ready = stalled ? 1'b0 : $urandom_range(99) >= spct;
      wr_valid = wr ? (wi <= len && $urandom_range(99) >= vpct) : 1'($urandom);
      wr_data = (wr && wi <= len) ? wq[wi] : 8'($urandom);
      rD = bits < total ? rq[bits/8][7-bits%8] : 1'($urandom);
      #1;
      if (cyc <= FW) ctl[FW-cyc] = control;
      else if (control) ctl_bad++;
      if (valid && ready) begin
        if (wr && (bits >= total || wD !== wq[bits/8][7-bits%8])) bit_bad++;
        bits++;
        lastx = cyc;
      end
      if (wr && !valid && wD) hold_bad++;
      if (wr && pv && !pr && (valid !== 1'b1 || wD !== pw)) hold_bad++;
      pv = valid; pr = ready; pw = wD;
      if (wr_valid && wr_ready) wi++;
      if (rd_valid) begin
        if (rc >= 16 || rd_data !== rq[rc]) bit_bad++;
        rc++;
      end
      if (done) begin dcnt++; dcyc = cyc; end
      if (err) begin ecnt++; if (ecyc < 0) ecyc = cyc; end
      if ((dcnt > 0 && cyc >= dcyc + 2) || (bad_sl && cyc >= 6) || cyc >= 3000) stop = 1;
    end
    chk("ctrl_frame", 32'(ctl), bad_sl ? 0 : 32'({1'b1, IW'(sl), wr}));
    chk("ctrl_idle_zero", ctl_bad, 0);
    chk("bus_bits", bits, total);
    chk("data_bits", bit_bad, 0);
    chk("hold_rules", hold_bad, 0);
    chk("wr_words", wi, (wr && !bad_sl) ? len + 1 : 0);
    chk("rd_words", rc, (wr || bad_sl) ? 0 : len + 1);
    chk("done_count", dcnt, bad_sl ? 0 : 1);
    chk("err_count", ecnt, bad_sl ? 1 : 0);
    chk("idle_after", cmd_ready, 1);
    if (bad_sl) chk("err_cycle", ecyc, 1);
    else chk("done_after_last_bit", dcyc, lastx + 1);
    if (exp_done >= 0) chk("done_cycle", dcyc, exp_done);
    cmd_valid = 0;
  endtask

  initial begin
    int dn, en, ecyc;
    logic ed;
    vecs[0] = '{2, 1'b1, 0,  8'hA5, 8'h00, -1, 0, 13};
    vecs[1] = '{1, 1'b0, 1,  8'h3C, 8'hC3, -1, 0, 21};
    vecs[2] = '{2, 1'b1, 0,  8'hFF, 8'h00, 4,  3, 16};
    vecs[3] = '{3, 1'b1, 0,  8'h55, 8'h00, -1, 0, -1};
    vecs[4] = '{0, 1'b1, 15, 8'h81, 8'h7E, -1, 0, 133};
    vecs[5] = '{2, 1'b0, 15, 8'h96, 8'h69, -1, 0, 133};
    #2;
    chk("rst_outs", 32'({control, wD, valid, wr_ready, rd_valid, done, err}), 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_data", 32'(rd_data), 0);
    @(negedge clk) rst = 0;
    foreach (vecs[i]) txn(vecs[i].sl, vecs[i].wr, vecs[i].len, vecs[i].w0, vecs[i].w1,
                          vecs[i].sbit, vecs[i].sn, 0, 0, vecs[i].exp_done);
    // reset while bit 4 of a write word is on the bus
    @(negedge clk);
    cmd_valid = 1; cmd_slave = 2; cmd_write = 1; cmd_len = 0; ready = 1; wr_valid = 0;
    @(negedge clk);
    cmd_valid = 0; wr_valid = 1; wr_data = 8'hA5;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      wr_valid = 0;
    end
    #1 chk("pre_rst_valid", valid, 1);
    rst = 1;
    #1 chk("mid_rst_outs", 32'({control, wD, valid, wr_ready, rd_valid, done, err}), 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk) rst = 0;
    dn = 0; en = 0;
    repeat (20) begin
      @(negedge clk);
      #1 dn += 32'(done); en += 32'(err);
    end
    chk("no_done_after_abort", dn + en, 0);
    txn(2, 1'b1, 0, 8'hA5, 8'h00, -1, 0, 0, 0, 13);
    // read with the slave never ready
    @(negedge clk);
    cmd_valid = 1; cmd_slave = 0; cmd_write = 0; cmd_len = 0; ready = 0;
    ecyc = -1; ed = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      cmd_valid = 0;
      #1 if (err && ecyc < 0) begin ecyc = c; ed = done; end
    end
`ifdef BUS_TIMEOUT_EN
    chk("timeout_cycle", ecyc, 3 + IW + TO);
    chk("timeout_done", ed, 1);
    chk("timeout_idle", cmd_ready, 1);
`else
    chk("no_timeout_err", ecyc, -1);
    chk("still_waiting", valid, 1);
`endif
    rst = 1;
    @(negedge clk) rst = 0;
    for (int n = 0; n < 40; n++)
      txn($urandom_range(NS), 1'($urandom_range(1)), $urandom_range(7), 8'($urandom), 8'($urandom),
          $urandom_range(20), $urandom_range(4), 30, 30, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
